// File: rtl/counter_cmd_master.sv
// Command-driven master for the 8-bit counter IP: turns op/arg commands into
// single-cycle latch/div/dec strobes and returns one response per command.
module counter_cmd_master #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic [WIDTH-1:0] cnt_in,
  output logic             cnt_latch,
  output logic             cnt_div,
  output logic             cnt_dec,
  input  logic [WIDTH-1:0] cnt_count,
  input  logic             cnt_zero,
  output logic             rsp_valid,
  output logic [1:0]       rsp_op,
  output logic [WIDTH-1:0] rsp_count,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             rsp_timeout,
  output logic             busy
);

  localparam int unsigned TW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_DIV   = 2'd1;
  localparam logic [1:0] OP_DEC   = 2'd2;
  localparam logic [1:0] OP_WAITZ = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STROBE  = 3'd1,
    DEC_RUN = 3'd2,
    WAIT_Z  = 3'd3,
    SETTLE  = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] arg_q;
  logic [WIDTH-1:0] rem_q, rem_nxt;
  logic [TW-1:0]    timer_q, timer_nxt;
  logic             err_q, err_nxt;
  logic             tmo_q, tmo_nxt;
  logic             accept;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Strobes are decoded from registered state so an async reset drops them at once.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem_q;
    timer_nxt = timer_q;
    err_nxt   = err_q;
    tmo_nxt   = tmo_q;
    cnt_latch = 1'b0;
    cnt_div   = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD, OP_DIV: state_nxt = STROBE;
            OP_DEC: begin
              state_nxt = DEC_RUN;
              rem_nxt   = cmd_arg;
            end
            OP_WAITZ: begin
              state_nxt = WAIT_Z;
              timer_nxt = '0;
            end
            default: state_nxt = IDLE;
          endcase
        end
      end
      STROBE: begin
        if (op_q == OP_LOAD) begin
          cnt_latch = 1'b1;
        end else if (arg_q != '0) begin
          cnt_div = 1'b1;
        end else begin
          err_nxt = 1'b1;
        end
        state_nxt = SETTLE;
      end
      // Never decrement while the counter reports zero.
      DEC_RUN: begin
        if (rem_q == '0 || cnt_zero) begin
          state_nxt = SETTLE;
        end else begin
          cnt_dec = 1'b1;
          rem_nxt = rem_q - WIDTH'(1);
        end
      end
      WAIT_Z: begin
        if (cnt_zero) begin
          state_nxt = SETTLE;
        end else if (timer_q == TW'(WAIT_MAX - 1)) begin
          tmo_nxt   = 1'b1;
          state_nxt = SETTLE;
        end else begin
          timer_nxt = timer_q + TW'(1);
        end
      end
      SETTLE: state_nxt = RESP;
      RESP: begin
        err_nxt   = 1'b0;
        tmo_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= '0;
      arg_q   <= '0;
      rem_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_in  <= '0;
    end else begin
      state   <= state_nxt;
      rem_q   <= rem_nxt;
      timer_q <= timer_nxt;
      err_q   <= err_nxt;
      tmo_q   <= tmo_nxt;
      if (accept) begin
        op_q  <= cmd_op;
        arg_q <= cmd_arg;
        // cnt_in only changes for a strobe that will actually fire.
        if (cmd_op == OP_LOAD || (cmd_op == OP_DIV && cmd_arg != '0)) begin
          cnt_in <= cmd_arg;
        end
      end
    end
  end

  // Response capture at the end of SETTLE; flags clear as RESP returns to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid   <= 1'b0;
      rsp_op      <= '0;
      rsp_count   <= '0;
      rsp_zero    <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= (state == SETTLE);
      if (state == SETTLE) begin
        rsp_op      <= op_q;
        rsp_count   <= cnt_count;
        rsp_zero    <= cnt_zero;
        rsp_err     <= err_q;
        rsp_timeout <= tmo_q;
      end else if (state == RESP) begin
        rsp_err     <= 1'b0;
        rsp_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_counter_cmd_master.sv
// Scoreboard bench: counter_cmd_master driving a behavioural 8-bit counter.
module tb_counter_cmd_master;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned WAIT_MAX = 8;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_DIV   = 2'd1;
  localparam logic [1:0] OP_DEC   = 2'd2;
  localparam logic [1:0] OP_WAITZ = 2'd3;

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] arg;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             err;
    logic             tmo;
    int               nl;
    int               nd;
    int               ndec;
    int               lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             ctr_rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic [WIDTH-1:0] cnt_in;
  logic             cnt_latch, cnt_div, cnt_dec;
  logic [WIDTH-1:0] cnt_count;
  logic             cnt_zero;
  logic             rsp_valid;
  logic [1:0]       rsp_op;
  logic [WIDTH-1:0] rsp_count;
  logic             rsp_zero, rsp_err, rsp_timeout;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int neg_cnt = 0;
  int acc_neg = 0;
  int rsp_last = -1;
  int n_latch = 0, n_div = 0, n_dec = 0;
  logic [WIDTH-1:0] mcount = '0;
  exp_t q[$];

  always #5 clk = ~clk;

  counter_cmd_master #(.WIDTH(WIDTH), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cnt_in(cnt_in), .cnt_latch(cnt_latch), .cnt_div(cnt_div), .cnt_dec(cnt_dec),
    .cnt_count(cnt_count), .cnt_zero(cnt_zero),
    .rsp_valid(rsp_valid), .rsp_op(rsp_op), .rsp_count(rsp_count), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  // Behavioural counter: latch loads, div divides, dec decrements.
  always @(posedge clk or posedge ctr_rst) begin
    if (ctr_rst) cnt_count <= '0;
    else if (cnt_latch) cnt_count <= cnt_in;
    else if (cnt_div && cnt_in != '0) cnt_count <= cnt_count / cnt_in;
    else if (cnt_dec) cnt_count <= cnt_count - WIDTH'(1);
  end
  assign cnt_zero = (cnt_count == '0);

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: strobe counting, cnt_in, and response scoreboard.
  always @(negedge clk) begin
    exp_t e;
    neg_cnt++;
    if (!reset) begin
      if (cmd_valid && cmd_ready) acc_neg = neg_cnt;
      if (cnt_latch) n_latch++;
      if (cnt_div) n_div++;
      if (cnt_dec) n_dec++;
      if (cnt_latch || cnt_div || cnt_dec)
        check("strobe_onehot", $countones({cnt_latch, cnt_div, cnt_dec}), 1);
      if ((cnt_latch || cnt_div) && q.size() > 0)
        check("cnt_in", int'(cnt_in), int'(q[0].arg));
      if (rsp_valid) begin
        rsp_last = neg_cnt;
        if (q.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          check("rsp_op", int'(rsp_op), int'(e.op));
          check("rsp_count", int'(rsp_count), int'(e.count));
          check("rsp_zero", int'(rsp_zero), int'(e.zero));
          check("rsp_err", int'(rsp_err), int'(e.err));
          check("rsp_timeout", int'(rsp_timeout), int'(e.tmo));
          check("n_latch", n_latch, e.nl);
          check("n_div", n_div, e.nd);
          check("n_dec", n_dec, e.ndec);
          check("latency", neg_cnt - acc_neg, e.lat);
          n_latch = 0;
          n_div = 0;
          n_dec = 0;
        end
      end
    end
  end

  // Predict the response from the bench's own counter model, then drive until accepted.
  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] arg);
    exp_t e;
    int n;
    int p;
    e.op = op; e.arg = arg; e.err = 1'b0; e.tmo = 1'b0;
    e.nl = 0; e.nd = 0; e.ndec = 0; e.lat = 3;
    case (op)
      OP_LOAD: begin mcount = arg; e.nl = 1; end
      OP_DIV: begin
        if (arg == '0) e.err = 1'b1;
        else begin mcount = mcount / arg; e.nd = 1; end
      end
      OP_DEC: begin
        p = (int'(arg) < int'(mcount)) ? int'(arg) : int'(mcount);
        mcount = mcount - WIDTH'(p);
        e.ndec = p;
        e.lat = p + 3;
      end
      default: begin
        if (mcount != '0) begin e.tmo = 1'b1; e.lat = WAIT_MAX + 2; end
      end
    endcase
    e.count = mcount;
    e.zero = (mcount == '0);
    q.push_back(e);
    cmd_op = op; cmd_arg = arg; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n == 100) check("accept_timeout", n, 0);
    else if (n > 0) check("bp_accept_after_rsp", rsp_last, neg_cnt);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin @(negedge clk); #1; k++; end
    check("rsp_pending", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1; ctr_rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_strobes", int'({cnt_latch, cnt_div, cnt_dec}), 0);
    check("rst_cnt_in", int'(cnt_in), 0);
    check("rst_rsp", int'({rsp_valid, rsp_err, rsp_timeout, rsp_zero}), 0);
    reset = 1'b0; ctr_rst = 1'b0;
    @(posedge clk); #1;

    issue(OP_LOAD, 8'd16);  wait_idle();
    issue(OP_DIV, 8'd2);    wait_idle();
    issue(OP_DIV, 8'd0);    wait_idle();
    issue(OP_LOAD, 8'd3);   wait_idle();
    issue(OP_DEC, 8'd5);    wait_idle();
    issue(OP_DEC, 8'd2);    wait_idle();
    issue(OP_LOAD, 8'd7);   wait_idle();
    issue(OP_DEC, 8'd0);    wait_idle();
    issue(OP_DEC, 8'd3);    wait_idle();
    issue(OP_LOAD, 8'd4);   wait_idle();
    issue(OP_WAITZ, 8'd0);  wait_idle();
    issue(OP_LOAD, 8'd0);   wait_idle();
    issue(OP_WAITZ, 8'd0);  wait_idle();

    // Backpressure: second command is presented while the first is in flight.
    issue(OP_LOAD, 8'd9);
    check("bp_busy", int'(busy), 1);
    issue(OP_DEC, 8'd4);
    issue(OP_DIV, 8'd5);
    wait_idle();

    // Abort a long DEC with reset after the tenth strobe.
    issue(OP_LOAD, 8'd200); wait_idle();
    issue(OP_DEC, 8'd100);
    k = 0;
    while (n_dec < 10 && k < 300) begin @(negedge clk); #1; k++; end
    check("abort_pulses", n_dec, 10);
    reset = 1'b1;
    #1;
    check("abort_dec", int'(cnt_dec), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_rsp", int'(rsp_valid), 0);
    // The strobe in flight at reset never reaches a clock edge.
    q.delete();
    mcount = WIDTH'(200 - (n_dec - 1));
    n_latch = 0; n_div = 0; n_dec = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_ready", int'(cmd_ready), 1);
    check("post_rst_busy", int'(busy), 0);
    repeat (20) @(negedge clk);
    issue(OP_DEC, 8'd1);    wait_idle();
    issue(OP_DIV, 8'd10);   wait_idle();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
